xcel_gcd_responder: RTL
=======================

# xcel_gcd_responder

Accelerator-side responder for the xcel request/response protocol. It accepts `xcel_req_t` register read/write requests from a processor, implements a small accelerator register file, and runs an iterative GCD (Euclid subtract/swap) datapath when started. It returns one `xcel_resp_t` per request. It is the target end that processor-side xcel initiators talk to, and it serves as the reference minion for xcel integration tests.

## Interface
Parameters:
- none. Widths are fixed by `xcel_req_t` (38b: type_ 1b, addr 5b, data 32b) and `xcel_resp_t` (33b: type_ 1b, data 32b).

Ports:
- `clk` in 1 — the single clock.
- `reset` in 1 — synchronous, active-high.
- `xcelreq_val` in 1 — request valid.
- `xcelreq_rdy` out 1 — responder can accept a request.
- `xcelreq_msg` in 38 — `xcel_req_t`.
- `xcelresp_val` out 1 — response valid.
- `xcelresp_rdy` in 1 — consumer accepts the response.
- `xcelresp_msg` out 33 — `xcel_resp_t`.

## Operation
- Register map:
  - xr0 write = go. The data field is ignored.
  - xr0 read = result.
  - xr1 = operand A, read/write.
  - xr2 = operand B, read/write.
  - xr3–xr31: writes are ignored; reads return 0.
- Every request produces exactly one response, in request order.
  - Response `type_` equals the request `type_`.
  - Write responses carry data 0.
- FSM states: IDLE, CALC.
- IDLE:
  - A request fires when `xcelreq_val && xcelreq_rdy`.
  - Read: the response data is sampled from the register value at fire time.
  - Write xr1/xr2: the register updates at the end of the fire cycle.
  - Write xr0: working regs load a←xr1, b←xr2, the write response is enqueued, and the next state is CALC.
- CALC: exactly one action per cycle, chosen in this priority order:
  1. a<b → swap a and b.
  2. b≠0 → a←a−b.
  3. b==0 → result←a, next state IDLE.
- 32-bit unsigned arithmetic. a−b never underflows because a≥b is guaranteed at subtract.
- gcd(x,0)=x and gcd(0,0)=0.
- xr1/xr2 are not modified by CALC; reads return the values last written.
- Response buffer: a single entry (`xcelresp_val`, `xcelresp_msg` registered).
  - Loaded on request fire.
  - Cleared on `xcelresp_val && xcelresp_rdy`, unless reloaded in the same cycle.
- `xcelreq_rdy = !reset && state==IDLE && (!xcelresp_val || xcelresp_rdy)`. This is combinational from state, the buffer and `xcelresp_rdy`.
- Reset values:
  - state IDLE.
  - `xcelresp_val` 0.
  - `xcelresp_msg` 0.
  - xr0, xr1, xr2, a, b all 0.
  - `xcelreq_rdy` is 0 while `reset` is high.
- Reset mid-CALC: abort, return to IDLE, clear all registers, and drop any pending response.

## Timing
- Request fire in cycle N → `xcelresp_val` high in cycle N+1.
  - The response holds stable until accepted.
  - Back-to-back: a new request can fire in the cycle the previous response is accepted, so throughput is 1 request/cycle with `xcelresp_rdy` held high.
- Go fire in cycle N:
  - Write response valid in N+1.
  - CALC occupies cycles N+1 … N+k, where k = number of swap + subtract + finish steps.
  - State is IDLE in N+k+1; `xcelreq_rdy` may rise then.
- Requests arriving during CALC stall (`xcelreq_rdy`=0). The response buffer still drains during CALC.
- `xcelresp_rdy` low: the buffer holds and `xcelreq_rdy` stays 0. There is no loss or duplication.
- A read of xr0 after go always returns the completed result, because reads cannot fire during CALC.
- After the first go, a read of xr0 returns the last completed result.

## Test plan
- Reset, then read xr0, xr1, xr2, and read xr7 → four responses rd:00000000. The first request fires no earlier than the cycle after reset deasserts.
- Write xr1=15, write xr2=5, go, read xr0:
  - Responses: wr, wr, wr, rd:00000005.
  - CALC lasts exactly 5 cycles: sub, sub, sub, swap, finish.
- Write xr1=0x0000001B, xr2=0x00000024 (27, 36), go, read xr0 → rd:00000009. Then read xr1 → rd:0000001B, confirming operands are unchanged.
- Edge operands:
  - gcd(7,0) → 7.
  - gcd(0,9) → 9, via swap then finish.
  - gcd(0,0) → 0, with CALC of 1 cycle.
  - gcd(0xFFFFFFFF,1) → 1. This is a long run; the cycle-count watchdog is ≥2^32 disabled, and only the result is checked.
- Backpressure: random `xcelresp_rdy` (50%) with a stream of 20 mixed writes/reads to xr1/xr2/xr31 → responses are in order with correct data and none are dropped. `xcelreq_rdy` is never high while the buffer is full and `xcelresp_rdy` is low.
- Assert reset 2 cycles into the CALC of gcd(100,1) → no response is emitted. A subsequent read of xr0 returns 0 and a read of xr1 returns 0.

Source files
------------

// File: rtl/xcel_gcd_responder_if.sv
// xcel_gcd_responder_if: xcel request/response handshake bundle
// master = processor side (drives requests, accepts responses)
// slave  = accelerator side (accepts requests, drives responses)
// xcelreq_msg  = {type_[37], addr[36:32], data[31:0]}, type_ 1 = write
// xcelresp_msg = {type_[32], data[31:0]}
interface xcel_gcd_responder_if;
  logic        xcelreq_val;
  logic        xcelreq_rdy;
  logic [37:0] xcelreq_msg;
  logic        xcelresp_val;
  logic        xcelresp_rdy;
  logic [32:0] xcelresp_msg;
  modport master (
    output xcelreq_val, xcelreq_msg, xcelresp_rdy,
    input  xcelreq_rdy, xcelresp_val, xcelresp_msg
  );
  modport slave (
    input  xcelreq_val, xcelreq_msg, xcelresp_rdy,
    output xcelreq_rdy, xcelresp_val, xcelresp_msg
  );
endinterface

// File: rtl/xcel_gcd_responder.sv
// xcel_gcd_responder: xcel register-file minion running an iterative Euclid GCD on go
// clk   : clock
// reset : synchronous active-high reset
// x     : request/response handshake (slave side)
// xr0 write = go, xr0 read = last result, xr1/xr2 = operands A/B, xr3..xr31 read 0
module xcel_gcd_responder (
  input logic                clk,
  input logic                reset,
  xcel_gcd_responder_if.slave x
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t      state_q, state_d;
  logic [31:0] xr0_q, xr0_d, xr1_q, xr1_d, xr2_q, xr2_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        resp_val_q, resp_val_d;
  logic [32:0] resp_msg_q, resp_msg_d;
  logic        rdy, fire, wr, go;
  logic [4:0]  addr;
  logic [31:0] wdata, rdata;
  // Only one response slot, so accept only when it is empty or draining this cycle.
  assign rdy            = !reset && state_q == IDLE && (!resp_val_q || x.xcelresp_rdy);
  assign x.xcelreq_rdy  = rdy;
  assign x.xcelresp_val = resp_val_q;
  assign x.xcelresp_msg = resp_msg_q;
  always_comb begin
    wr         = x.xcelreq_msg[37];
    addr       = x.xcelreq_msg[36:32];
    wdata      = x.xcelreq_msg[31:0];
    fire       = x.xcelreq_val && rdy;
    go         = fire && wr && addr == 5'd0;
    rdata      = addr == 5'd0 ? xr0_q : addr == 5'd1 ? xr1_q : addr == 5'd2 ? xr2_q : 32'd0;
    resp_val_d = fire || (resp_val_q && !x.xcelresp_rdy);
    resp_msg_d = fire ? {wr, wr ? 32'd0 : rdata} : resp_msg_q;
    xr1_d      = fire && wr && addr == 5'd1 ? wdata : xr1_q;
    xr2_d      = fire && wr && addr == 5'd2 ? wdata : xr2_q;
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    xr0_d      = xr0_q;
    if (go) begin
      state_d = CALC;
      a_d     = xr1_q;
      b_d     = xr2_q;
    end else if (state_q == CALC) begin
      if (a_q < b_q) begin
        a_d = b_q;
        b_d = a_q;
      end else if (b_q != 32'd0) begin
        a_d = a_q - b_q;
      end else begin
        xr0_d   = a_q;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      xr0_q      <= '0;
      xr1_q      <= '0;
      xr2_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      resp_val_q <= 1'b0;
      resp_msg_q <= '0;
    end else begin
      state_q    <= state_d;
      xr0_q      <= xr0_d;
      xr1_q      <= xr1_d;
      xr2_q      <= xr2_d;
      a_q        <= a_d;
      b_q        <= b_d;
      resp_val_q <= resp_val_d;
      resp_msg_q <= resp_msg_d;
    end
  end
endmodule
